jelly2_jfive_wb_uart_tx: RTL
============================

JELLY2_JFIVE_WB_UART_TX -- requirements
Module: jelly2_jfive_wb_uart_tx

Interface
REQ-001 The block SHALL provide parameter WB_ADR_WIDTH, default 24, as the Wishbone word-address width.
REQ-002 The block SHALL provide parameter WB_DAT_WIDTH, default 32, as the data width; SEL width is WB_DAT_WIDTH/8.
REQ-003 The block SHALL provide parameter FIFO_PTR_WIDTH, default 4, giving a TX FIFO depth of 2^FIFO_PTR_WIDTH (16).
REQ-004 The block SHALL provide parameter DIVIDER_WIDTH, default 16, as the baud-divider width.
REQ-005 The block SHALL provide parameter INIT_DIVIDER, default 867, as the reset divider value.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk, input, 1, the single clock.
REQ-008 reset_n, input, 1, asynchronous active-low reset.
REQ-009 cke, input, 1, clock enable; all state holds while cke=0.
REQ-010 s_wb_adr_i, input, WB_ADR_WIDTH, word address.
REQ-011 s_wb_dat_i, input, WB_DAT_WIDTH, write data.
REQ-012 s_wb_dat_o, output, WB_DAT_WIDTH, read data.
REQ-013 s_wb_sel_i, input, WB_DAT_WIDTH/8, byte enables.
REQ-014 s_wb_we_i, input, 1, write strobe qualifier.
REQ-015 s_wb_stb_i, input, 1, request; master holds it and all other inputs until ack.
REQ-016 s_wb_ack_o, output, 1, one-cycle registered acknowledge.
REQ-017 uart_tx, output, 1, serial line, 8N1, idle high.
REQ-018 irq, output, 1, level: FIFO empty and transmitter idle.

Function
REQ-019 Register map, word address: 0 TX_DATA (W: push dat_i[7:0] when sel[0]=1; R: 0). 1 STATUS (R: bit0 full, bit1 empty, bit2 busy, bits[15:8] FIFO count; others 0). 2 DIVIDER (R/W, bits[DIVIDER_WIDTH-1:0], sel-masked per byte). Other addresses SHALL read 0 and ignore writes.
REQ-020 Ack SHALL be set on the edge sampling stb=1, ack=0, and ready; it SHALL clear on the following edge, so never two consecutive cycles high.
REQ-021 Ready SHALL be 1 except for a TX_DATA write with sel[0]=1 while FIFO full, which SHALL wait-state until not full.
REQ-022 Write side effects and read data SHALL be registered on the same edge that sets ack; s_wb_dat_o SHALL be 0 whenever ack=0.
REQ-023 Transmitter FSM states: IDLE, START, DATA, STOP. IDLE with FIFO non-empty SHALL pop on that edge and enter START.
REQ-024 Each bit SHALL last DIVIDER+1 cke-enabled cycles; DIVIDER is sampled at every bit start, so mid-frame writes take effect at the next bit boundary.
REQ-025 START drives 0; DATA drives bits 0..7 LSB first with a 3-bit counter; STOP drives 1.
REQ-026 At the end of STOP, a non-empty FIFO SHALL pop and go directly to START with no idle bit; otherwise go to IDLE.
REQ-027 A simultaneous push and pop on one edge SHALL leave count unchanged; pointers wrap modulo depth; count width is FIFO_PTR_WIDTH+1.
REQ-028 busy SHALL be 1 in any state other than IDLE.
REQ-029 With cke=0, the FSM, bit counter, divider counter, FIFO and ack SHALL hold; uart_tx SHALL hold its value.

Reset
REQ-030 On reset_n=0, asynchronously: uart_tx=1, s_wb_ack_o=0, s_wb_dat_o=0, FIFO empty (count 0), DIVIDER=INIT_DIVIDER, FSM IDLE, irq=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame, discard FIFO contents, and return uart_tx high immediately.

Verification
REQ-032 Reset, read STATUS -> ack one cycle after stb, dat_o=0x0000_0002, irq=1, uart_tx=1.
REQ-033 Write DIVIDER=3, then TX_DATA=0x41 -> uart_tx = 0,1,0,0,0,0,0,1,0,1, each for 4 cycles (40 cycles total), then irq=1.
REQ-034 DIVIDER=3, write 0x55 and 0xAA back to back -> 20 bit periods with no idle gap between the stop of 0x55 and the start of 0xAA.
REQ-035 DIVIDER=1000, 18 consecutive TX_DATA writes -> 17 acked without wait states (1 in shifter, 16 in FIFO, STATUS full=1, count=16); 18th acked only after the second pop.
REQ-036 Toggle cke low 50 cycles mid-DATA -> uart_tx and STATUS frozen; frame resumes with bit timing intact.
REQ-037 Assert reset_n low during bit 3 of a frame with 5 bytes queued -> uart_tx=1 at once; STATUS=0x0000_0002 after release; no further frames sent.

Source files
------------

// File: rtl/jelly2_jfive_wb_uart_tx.sv
// Wishbone-attached UART transmitter, 8N1, with a TX FIFO.
// Registers: 0 TX_DATA, 1 STATUS, 2 DIVIDER.
module jelly2_jfive_wb_uart_tx #(
  parameter int WB_ADR_WIDTH   = 24,
  parameter int WB_DAT_WIDTH   = 32,
  parameter int FIFO_PTR_WIDTH = 4,
  parameter int DIVIDER_WIDTH  = 16,
  parameter int INIT_DIVIDER   = 867
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cke,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_we_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic                      uart_tx,
  output logic                      irq
);

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam int CW    = FIFO_PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  logic [DIVIDER_WIDTH-1:0]  divider;
  logic [DIVIDER_WIDTH-1:0]  div_mask;
  logic [WB_DAT_WIDTH-1:0]   rdata;

  logic                      is_tx;
  logic                      is_status;
  logic                      is_div;
  logic                      wr_tx;
  logic                      ready;
  logic                      acc;
  logic                      push;
  logic                      div_we;

  logic [7:0]                mem [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]             count;
  logic                      full;
  logic                      empty;
  logic [7:0]                fifo_rd;
  logic                      pop;

  state_t                    state;
  state_t                    state_n;
  logic [DIVIDER_WIDTH-1:0]  cnt;
  logic [DIVIDER_WIDTH-1:0]  cnt_n;
  logic [2:0]                bitc;
  logic [2:0]                bit_n;
  logic [7:0]                sh;
  logic [7:0]                sh_n;
  logic                      tx_n;
  logic                      busy;

  logic                      unused;

  assign unused = ^{s_wb_dat_i, s_wb_sel_i};

  assign is_tx     = (s_wb_adr_i == WB_ADR_WIDTH'(0));
  assign is_status = (s_wb_adr_i == WB_ADR_WIDTH'(1));
  assign is_div    = (s_wb_adr_i == WB_ADR_WIDTH'(2));

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != ST_IDLE);
  assign irq   = empty && !busy;

  assign wr_tx  = s_wb_stb_i && s_wb_we_i && is_tx && s_wb_sel_i[0];
  assign ready  = !(wr_tx && full);
  assign acc    = cke && s_wb_stb_i && !s_wb_ack_o && ready;
  assign push   = acc && wr_tx;
  assign div_we = acc && s_wb_we_i && is_div;

  assign fifo_rd = mem[rd_ptr];

  // byte-enable mask for the divider register
  always_comb begin
    div_mask = '0;
    for (int i = 0; i < DIVIDER_WIDTH; i++) begin
      div_mask[i] = s_wb_sel_i[i/8];
    end
  end

  // read mux; writes and unmapped addresses return zero
  always_comb begin
    rdata = '0;
    if (!s_wb_we_i) begin
      unique case (1'b1)
        is_status: begin
          rdata[0]         = full;
          rdata[1]         = empty;
          rdata[2]         = busy;
          rdata[8 +: CW]   = count;
        end
        is_div: begin
          rdata[DIVIDER_WIDTH-1:0] = divider;
        end
        default: ;
      endcase
    end
  end

  // bus acknowledge, registered read data and divider register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
      divider    <= DIVIDER_WIDTH'(INIT_DIVIDER);
    end else if (cke) begin
      s_wb_ack_o <= acc;
      s_wb_dat_o <= acc ? rdata : '0;
      if (div_we) begin
        divider <= (divider & ~div_mask)
                 | (s_wb_dat_i[DIVIDER_WIDTH-1:0] & div_mask);
      end
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (cke && push) begin
      mem[wr_ptr] <= s_wb_dat_i[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cke) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // transmitter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bitc    <= '0;
      sh      <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitc    <= bit_n;
      sh      <= sh_n;
      uart_tx <= tx_n;
    end
  end

  // transmitter next state; divider sampled at every bit start
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bitc;
    sh_n    = sh;
    tx_n    = uart_tx;
    pop     = 1'b0;
    if (cke) begin
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = fifo_rd;
            tx_n    = 1'b0;
            cnt_n   = divider;
            state_n = ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            state_n = ST_DATA;
            bit_n   = '0;
            tx_n    = sh[0];
            cnt_n   = divider;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            cnt_n = divider;
            if (bitc == 3'd7) begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end else begin
              bit_n = bitc + 1'b1;
              sh_n  = {1'b0, sh[7:1]};
              tx_n  = sh[1];
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            if (!empty) begin
              pop     = 1'b1;
              sh_n    = fifo_rd;
              tx_n    = 1'b0;
              cnt_n   = divider;
              state_n = ST_START;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule
